canden_ctrl: RTL and testbench
==============================

Name: canden_ctrl

Overview:
- Sequencer that drives the SEN/DEN/DYNEN enable inputs of a CANDEN clock-gate primitive from the ungated CLKIN domain.
- Runs a 4-phase REQ/ACK wake handshake with downstream clients.
- Auto-gates the clock after a programmable idle period.
- Supports static gating (DEN=0) and dynamic gating (DEN=1, DYNEN passed through).
- All enable outputs are retimed on the falling edge of CLKIN, so the AND-style gate never sees an enable edge while CLKIN is high.

Parameters:
- WAKE_CYCLES, 2: cycles SEN is held high before ACK is granted (clock settle). Legal range ≥1.
- IDLE_CYCLES, 16: idle cycles in COOL before the clock is gated off. Legal range ≥1.
- CNT_W, 8: counter width. Must hold max(WAKE_CYCLES, IDLE_CYCLES)-1; elaboration error otherwise.

Ports:
- CLKIN, input, 1: free-running ungated clock. All state on rising edge; retime flops on falling edge.
- RSTN, input, 1: asynchronous, active-low reset.
- REQ, input, 1: client request for a running gated clock (4-phase).
- ACK, output, 1: gated clock running and granted.
- BUSY, input, 1: activity from the gated domain. Holds the clock on.
- FORCE_ON, input, 1: keep the clock on regardless of REQ/BUSY.
- MODE, input, 1: 0 = static gating, 1 = dynamic gating. Sampled only in OFF.
- DYN_EN_IN, input, 1: per-cycle dynamic enable, used only when ON and latched MODE=1.
- SEN, output, 1: static enable to CANDEN. Negedge-retimed.
- DEN, output, 1: dynamic-select to CANDEN. Negedge-retimed.
- DYNEN, output, 1: dynamic enable to CANDEN. Negedge-retimed.
- STATE, output, 2: current FSM state, for status/debug.

Behaviour:
- Reset (RSTN=0, asynchronous):
  - State = OFF, both counters = 0, mode latch = 0.
  - ACK = 0, and SEN/DEN/DYNEN = 0 immediately, including the negedge flops.
  - Reset mid-operation stops the gated clock at once. ACK drops without waiting for REQ.
- States and encodings: OFF = 00, WAKE = 01, ON = 10, COOL = 11.
- OFF:
  - Raw SEN = 0; mode latch <= MODE on every edge.
  - REQ | FORCE_ON -> WAKE, with wake counter = WAKE_CYCLES-1.
- WAKE:
  - Raw SEN = 1. If counter = 0 -> ON; otherwise decrement.
  - REQ dropping during WAKE does not abort; the FSM enters ON, then COOL.
- ON:
  - Raw SEN = 1.
  - If REQ=0, BUSY=0 and FORCE_ON=0 -> COOL, with idle counter = IDLE_CYCLES-1.
- COOL:
  - Raw SEN = 1.
  - REQ | BUSY | FORCE_ON -> ON, which takes priority over expiry in the same cycle.
  - Otherwise, if counter = 0 -> OFF; else decrement.
- ACK:
  - Registered: ACK <= (next_state == ON) & REQ.
  - ACK falls on the first edge that samples REQ=0 (4-phase).
  - REQ->ACK latency from OFF = WAKE_CYCLES+1 rising edges, counting the edge that samples REQ=1 as edge 1.
  - From COOL the latency is 1 edge.
- DEN / DYNEN:
  - Raw DEN = (state == ON) & mode latch.
  - Raw DYNEN = raw DEN & DYN_EN_IN.
  - In WAKE and COOL, DEN = 0, so the clock runs statically; this guarantees the settle and drain cycles are clocked.
- Retime: SEN/DEN/DYNEN are captured from the raw values on the falling edge of CLKIN, giving a half-cycle lag after each state change.
- MODE changes outside OFF are ignored until the next OFF visit.
- Counters never wrap: they load on state entry and stop at 0.

Decomposition:
- Package canden_ctrl_pkg: 2-bit state enum with the encodings above, plus the encoding constants shared with the status register map.
- Sub-module canden_ctrl_retime: three negedge flops with async active-low clear.
- Top level: FSM, counters, ACK, mode latch.

Test Plan:
1. Wake latency. WAKE_CYCLES=2, MODE=0; REQ rises before edge 1.
   -> STATE 01 at edge 1, 10 at edge 3; ACK=1 after edge 3.
   -> SEN=1 from the falling edge after edge 1; DEN=0 throughout.
2. Idle gating. IDLE_CYCLES=4; REQ and BUSY drop, sampled at edge n.
   -> ACK=0 after n; STATE 11 at n, 00 at n+4.
   -> SEN falls at the falling edge after n+4; no SEN edge while CLKIN is high.
3. COOL re-entry. BUSY=1 at the cycle the idle counter reaches 0.
   -> STATE returns to 10, not 00; SEN stays 1.
   -> A later REQ gets ACK after 1 edge.
4. Dynamic mode. MODE=1 latched in OFF; in ON, DYN_EN_IN toggles 1,0,1.
   -> DEN=1; DYNEN follows 1,0,1 with a half-cycle lag.
   -> MODE=0 while ON leaves DEN=1 until the next OFF.
5. FORCE_ON. With REQ=0, FORCE_ON=1 -> WAKE -> ON, ACK stays 0, STATE holds 10 indefinitely. Releasing FORCE_ON -> COOL.
6. Async reset. RSTN pulsed low while in ON with ACK=1.
   -> SEN/DEN/DYNEN/ACK = 0 immediately, without a clock edge; STATE = 00.
   -> After release, the next REQ again takes WAKE_CYCLES+1 edges to ACK.

Source files
------------

// File: rtl/canden_ctrl_pkg.sv
// canden_ctrl_pkg
// Shared definitions for the CANDEN enable sequencer.
//   - STATE_ENC_* : 2-bit state encodings, also used by the status register map.
//   - state_e     : FSM state type built on those encodings.
package canden_ctrl_pkg;

    localparam logic [1:0] STATE_ENC_OFF  = 2'b00;
    localparam logic [1:0] STATE_ENC_WAKE = 2'b01;
    localparam logic [1:0] STATE_ENC_ON   = 2'b10;
    localparam logic [1:0] STATE_ENC_COOL = 2'b11;

    typedef enum logic [1:0] {
        ST_OFF  = STATE_ENC_OFF,
        ST_WAKE = STATE_ENC_WAKE,
        ST_ON   = STATE_ENC_ON,
        ST_COOL = STATE_ENC_COOL
    } state_e;

endpackage

// File: rtl/canden_ctrl_retime.sv
// canden_ctrl_retime
// Falling-edge retiming of the three CANDEN enables. Because the enables
// only move while CLKIN is low, the AND-style gate never sees an enable edge
// during the high phase of the clock.
// Ports:
//   clk      : free-running ungated clock (flops capture on its falling edge)
//   rst_n    : asynchronous active-low clear
//   sen_d    : raw static enable
//   den_d    : raw dynamic-select
//   dynen_d  : raw dynamic enable
//   sen_q, den_q, dynen_q : retimed enables to the gate primitive
module canden_ctrl_retime (
    input  logic clk,
    input  logic rst_n,
    input  logic sen_d,
    input  logic den_d,
    input  logic dynen_d,
    output logic sen_q,
    output logic den_q,
    output logic dynen_q
);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sen_q   <= 1'b0;
            den_q   <= 1'b0;
            dynen_q <= 1'b0;
        end else begin
            sen_q   <= sen_d;
            den_q   <= den_d;
            dynen_q <= dynen_d;
        end
    end

endmodule

// File: rtl/canden_ctrl.sv
// canden_ctrl
// Sequences the SEN/DEN/DYNEN inputs of a CANDEN clock gate. Clients wake
// the gated clock with a 4-phase REQ/ACK handshake; the clock is gated off
// after IDLE_CYCLES quiet cycles. DEN selects dynamic gating (DYNEN passed
// through) only while ON with the latched MODE set.
// Handshake: REQ is held high by the client until ACK is seen high, then
// dropped; ACK follows REQ low on the first edge that samples REQ=0.
// Ports:
//   CLKIN     : free-running ungated clock
//   RSTN      : asynchronous active-low reset
//   REQ / ACK : 4-phase wake request / grant
//   BUSY      : gated-domain activity, holds the clock on
//   FORCE_ON  : keep the clock on unconditionally
//   MODE      : 0 static, 1 dynamic gating (latched only in OFF)
//   DYN_EN_IN : per-cycle dynamic enable
//   SEN/DEN/DYNEN : retimed enables to CANDEN
//   STATE     : current FSM state (debug/status)
module canden_ctrl
    import canden_ctrl_pkg::*;
#(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic       CLKIN,
    input  logic       RSTN,
    input  logic       REQ,
    output logic       ACK,
    input  logic       BUSY,
    input  logic       FORCE_ON,
    input  logic       MODE,
    input  logic       DYN_EN_IN,
    output logic       SEN,
    output logic       DEN,
    output logic       DYNEN,
    output logic [1:0] STATE
);

    if (WAKE_CYCLES < 1 || IDLE_CYCLES < 1) begin : g_bad_cycles
        $error("canden_ctrl: WAKE_CYCLES and IDLE_CYCLES must be >= 1");
    end
    if ((WAKE_CYCLES - 1) >= (1 << CNT_W) || (IDLE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("canden_ctrl: CNT_W too small for WAKE_CYCLES/IDLE_CYCLES");
    end

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             mode_q,     mode_d;
    logic             ack_q,      ack_d;

    logic sen_raw;
    logic den_raw;
    logic dynen_raw;

    always_ff @(posedge CLKIN or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= ST_OFF;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
            mode_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            mode_q     <= mode_d;
            ack_q      <= ack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        idle_cnt_d = idle_cnt_q;
        mode_d     = mode_q;
        case (state_q)
            ST_OFF: begin
                mode_d = MODE;
                if (REQ || FORCE_ON) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // REQ is deliberately ignored here: an aborted wake still
                // passes through ON so the settle is never cut short.
                if (wake_cnt_q == '0) begin
                    state_d = ST_ON;
                end else begin
                    wake_cnt_d = wake_cnt_q - 1'b1;
                end
            end
            ST_ON: begin
                if (!REQ && !BUSY && !FORCE_ON) begin
                    state_d    = ST_COOL;
                    idle_cnt_d = IDLE_LOAD;
                end
            end
            ST_COOL: begin
                // Renewed activity wins over expiry in the same cycle.
                if (REQ || BUSY || FORCE_ON) begin
                    state_d = ST_ON;
                end else if (idle_cnt_q == '0) begin
                    state_d = ST_OFF;
                end else begin
                    idle_cnt_d = idle_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_OFF;
        endcase
        ack_d = (state_d == ST_ON) && REQ;
    end

    // WAKE and COOL keep the clock running statically so that the settle
    // and drain cycles are always clocked.
    assign sen_raw   = (state_q != ST_OFF);
    assign den_raw   = (state_q == ST_ON) && mode_q;
    assign dynen_raw = den_raw && DYN_EN_IN;

    canden_ctrl_retime u_retime (
        .clk     (CLKIN),
        .rst_n   (RSTN),
        .sen_d   (sen_raw),
        .den_d   (den_raw),
        .dynen_d (dynen_raw),
        .sen_q   (SEN),
        .den_q   (DEN),
        .dynen_q (DYNEN)
    );

    assign ACK   = ack_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_canden_ctrl.sv
// tb_canden_ctrl
// Directed scenarios followed by random stimulus. A timing-level reference
// (edges spent waking / idling) predicts STATE, ACK and the enables; a compare
// process checks them after every clock edge, and directed steps add literal
// expectations at the key instants.
module tb_canden_ctrl;

    localparam int WAKE = 2;
    localparam int IDLE = 4;

    logic       CLKIN = 1'b0;
    logic       RSTN  = 1'b0;
    logic       REQ = 1'b0, BUSY = 1'b0, FORCE_ON = 1'b0, MODE = 1'b0, DYN_EN_IN = 1'b0;
    logic       ACK, SEN, DEN, DYNEN;
    logic [1:0] STATE;

    canden_ctrl #(.WAKE_CYCLES(WAKE), .IDLE_CYCLES(IDLE), .CNT_W(8)) dut (
        .CLKIN(CLKIN), .RSTN(RSTN), .REQ(REQ), .ACK(ACK), .BUSY(BUSY),
        .FORCE_ON(FORCE_ON), .MODE(MODE), .DYN_EN_IN(DYN_EN_IN),
        .SEN(SEN), .DEN(DEN), .DYNEN(DYNEN), .STATE(STATE)
    );

    // ---------------- clock ----------------
    always #5 CLKIN = ~CLKIN;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference ----------------
    // m_phase: 0 off, 1 waking, 2 on, 3 cooling (values equal the STATE codes).
    int m_phase = 0;
    int m_woke  = 0;   // edges spent waking
    int m_idle  = 0;   // quiet edges spent cooling
    bit m_mode  = 0;
    bit m_ack   = 0;

    initial begin
        forever begin
            @(posedge CLKIN or negedge RSTN);
            if (!RSTN) begin
                m_phase = 0; m_woke = 0; m_idle = 0; m_mode = 0; m_ack = 0;
            end else begin
                case (m_phase)
                    0: begin
                        m_mode = MODE;
                        if (REQ || FORCE_ON) begin m_phase = 1; m_woke = 0; end
                    end
                    1: begin
                        m_woke++;
                        if (m_woke == WAKE) m_phase = 2;
                    end
                    2: if (!REQ && !BUSY && !FORCE_ON) begin m_phase = 3; m_idle = 0; end
                    default: begin
                        if (REQ || BUSY || FORCE_ON) m_phase = 2;
                        else begin
                            m_idle++;
                            if (m_idle == IDLE) m_phase = 0;
                        end
                    end
                endcase
                m_ack = (m_phase == 2) && REQ;
            end
        end
    end

    // ---------------- compare process ----------------
    // After a falling edge the enables must reflect the current phase; after a
    // rising edge they must still hold what the previous falling edge took.
    bit last_sen = 0, last_den = 0, last_dyn = 0;
    bit cmp_en = 1;

    initial begin
        forever begin
            @(posedge CLKIN or negedge CLKIN);
            #1;
            if (!RSTN) begin
                last_sen = 0; last_den = 0; last_dyn = 0;
                chk("rst_outputs", {STATE, ACK, SEN, DEN, DYNEN}, 6'b0);
            end else if (cmp_en) begin
                bit es, ed, ey;
                if (CLKIN == 1'b0) begin
                    es = (m_phase != 0);
                    ed = (m_phase == 2) && m_mode;
                    ey = ed && DYN_EN_IN;
                    chk("neg_sen",   SEN,   es);
                    chk("neg_den",   DEN,   ed);
                    chk("neg_dynen", DYNEN, ey);
                    last_sen = es; last_den = ed; last_dyn = ey;
                end else begin
                    chk("pos_state", STATE, m_phase[1:0]);
                    chk("pos_ack",   ACK,   m_ack);
                    chk("pos_hold_en", {SEN, DEN, DYNEN}, {last_sen, last_den, last_dyn});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLKIN);
            #2;
        end
    endtask

    task automatic at_neg();
        @(negedge CLKIN);
        #1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        #1;
        chk("reset_state", {STATE, ACK, SEN, DEN, DYNEN}, 6'b0);
        tick(2);
        RSTN = 1'b1;
        tick(1);

        // 1. wake latency
        REQ = 1'b1;
        tick(1);
        chk("t1_state_e1", STATE, 2'b01);
        chk("t1_ack_e1", ACK, 1'b0);
        chk("t1_sen_before_neg", SEN, 1'b0);
        at_neg();
        chk("t1_sen_neg1", SEN, 1'b1);
        tick(1);
        chk("t1_state_e2", STATE, 2'b01);
        tick(1);
        chk("t1_state_e3", STATE, 2'b10);
        chk("t1_ack_e3", ACK, 1'b1);
        chk("t1_den", DEN, 1'b0);

        // 2. idle gating
        REQ = 1'b0;
        tick(1);
        chk("t2_state_n", STATE, 2'b11);
        chk("t2_ack_n", ACK, 1'b0);
        tick(3);
        chk("t2_state_n3", STATE, 2'b11);
        tick(1);
        chk("t2_state_n4", STATE, 2'b00);
        chk("t2_sen_high_phase", SEN, 1'b1);
        at_neg();
        chk("t2_sen_off", SEN, 1'b0);

        // 3. COOL re-entry at expiry
        REQ = 1'b1;
        tick(3);
        REQ = 1'b0;
        tick(4);              // cooling, last quiet edge before expiry next
        BUSY = 1'b1;
        tick(1);
        chk("t3_reenter", STATE, 2'b10);
        chk("t3_sen", SEN, 1'b1);
        BUSY = 1'b0;
        tick(1);
        chk("t3_cool", STATE, 2'b11);
        REQ = 1'b1;
        tick(1);
        chk("t3_ack_1edge", ACK, 1'b1);
        REQ = 1'b0;
        tick(1 + IDLE);
        chk("t3_off", STATE, 2'b00);

        // 4. dynamic mode
        MODE = 1'b1;
        tick(1);
        REQ = 1'b1; DYN_EN_IN = 1'b1;
        tick(3);
        at_neg();
        chk("t4_den", DEN, 1'b1);
        chk("t4_dyn1", DYNEN, 1'b1);
        tick(1); DYN_EN_IN = 1'b0;
        at_neg();
        chk("t4_dyn0", DYNEN, 1'b0);
        tick(1); DYN_EN_IN = 1'b1;
        at_neg();
        chk("t4_dyn1b", DYNEN, 1'b1);
        tick(1); MODE = 1'b0;
        tick(2);
        at_neg();
        chk("t4_den_kept", DEN, 1'b1);
        tick(1); REQ = 1'b0;
        tick(1 + IDLE + 1);

        // 5. FORCE_ON
        FORCE_ON = 1'b1;
        tick(3);
        chk("t5_on", STATE, 2'b10);
        chk("t5_ack", ACK, 1'b0);
        tick(20);
        chk("t5_hold", STATE, 2'b10);
        FORCE_ON = 1'b0;
        tick(1);
        chk("t5_cool", STATE, 2'b11);
        tick(IDLE);

        // 6. async reset while granted
        MODE = 1'b1; DYN_EN_IN = 1'b1;
        tick(1);
        REQ = 1'b1;
        tick(3);
        at_neg();
        chk("t6_pre", {STATE, ACK, SEN, DEN, DYNEN}, 6'b101111);
        #2;                   // clock low, well clear of any edge
        RSTN = 1'b0;
        #1;
        chk("t6_async", {STATE, ACK, SEN, DEN, DYNEN}, 6'b0);
        tick(1);
        RSTN = 1'b1;
        tick(1);
        chk("t6_e1", ACK, 1'b0);
        tick(1);
        chk("t6_e2", ACK, 1'b0);
        tick(1);
        chk("t6_e3", ACK, 1'b1);
        REQ = 1'b0; MODE = 1'b0; DYN_EN_IN = 1'b0;
        tick(2 + IDLE);

        // random phase
        for (int c = 0; c < 2000; c++) begin
            REQ       = ($urandom_range(0, 3) == 0);
            BUSY      = ($urandom_range(0, 4) == 0);
            FORCE_ON  = ($urandom_range(0, 15) == 0);
            MODE      = $urandom_range(0, 1);
            DYN_EN_IN = $urandom_range(0, 1);
            if ($urandom_range(0, 199) == 0) begin
                RSTN = 1'b0;
                tick(1);
                RSTN = 1'b1;
            end
            tick(1);
        end

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
